// File: rtl/cook_pkg.sv
// Shared definitions for the microwave cook sequencer: controller states and
// the BCD entry-register geometry.
package cook_pkg;
   localparam int DIGIT_W    = 4;
   localparam int NUM_DIGITS = 3;
   localparam int ENTRY_W    = DIGIT_W * NUM_DIGITS;

   typedef enum logic [2:0] {
      CLR   = 3'd0,
      IDLE  = 3'd1,
      ENTRY = 3'd2,
      LOAD  = 3'd3,
      COOK  = 3'd4,
      PAUSE = 3'd5,
      DONE  = 3'd6
   } state_t;

   // Keypad codes above 9 are not BCD digits and must never enter the timer.
   function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
      return d <= DIGIT_W'(9);
   endfunction
endpackage

// File: rtl/tick_div.sv
// Free-running 1 s tick divider; holds when not running, terminal-count tick
// is combinational so the controller can gate it in the same cycle.
module tick_div #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (run) begin
         count_reg <= (count_reg == TERM) ? '0 : count_reg + 1'b1;
      end
   end

   assign tick = (count_reg == TERM);
endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook controller: keypad entry, load/clear of the external BCD
// down-counter chain, 1 Hz count enable, door interlock and end beeper.
module cook_sequencer
   import cook_pkg::*;
#(
   parameter int TICK_DIV   = 50000000,
   parameter int BEEP_TICKS = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_valid,
   input  logic [DIGIT_W-1:0] key_digit,
   input  logic               start_btn,
   input  logic               stop_btn,
   input  logic               clear_btn,
   input  logic               door_closed,
   input  logic               timer_zero,
   output logic [ENTRY_W-1:0] load_val,
   output logic               load_n,
   output logic               clr_n,
   output logic               cnt_en,
   output logic               magnetron_on,
   output logic               lamp_on,
   output logic               beep
);
   localparam int BW = (BEEP_TICKS > 0) ? $clog2(BEEP_TICKS + 1) : 1;

   state_t             state_reg, state_next;
   logic [ENTRY_W-1:0] entry_reg, entry_next;
   logic [BW-1:0]      beep_cnt_reg, beep_cnt_next;
   logic               tick, div_run, div_clear, key_ok;

   tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
      .clk   (clk),
      .rst   (rst),
      .run   (div_run),
      .clear (div_clear),
      .tick  (tick)
   );

   assign key_ok = key_valid && is_bcd(key_digit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= CLR;
         entry_reg    <= '0;
         beep_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         entry_reg    <= entry_next;
         beep_cnt_reg <= beep_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      entry_next    = entry_reg;
      beep_cnt_next = '0;
      div_run       = 1'b0;
      div_clear     = 1'b0;
      load_n        = 1'b1;
      clr_n         = 1'b1;
      cnt_en        = 1'b0;
      magnetron_on  = 1'b0;
      lamp_on       = 1'b0;
      beep          = 1'b0;
      unique case (state_reg)
         CLR: begin
            clr_n      = 1'b0;
            entry_next = '0;
            state_next = IDLE;
         end
         IDLE: begin
            if (key_ok) begin
               entry_next = {entry_reg[ENTRY_W-DIGIT_W-1:0], key_digit};
               state_next = ENTRY;
            end
         end
         ENTRY: begin
            // A qualifying start swallows a simultaneous key press.
            if (clear_btn) begin
               state_next = CLR;
            end else if (start_btn && door_closed && (entry_reg != '0)) begin
               state_next = LOAD;
            end else if (key_ok) begin
               entry_next = {entry_reg[ENTRY_W-DIGIT_W-1:0], key_digit};
            end
         end
         LOAD: begin
            load_n     = 1'b0;
            div_clear  = 1'b1;
            state_next = COOK;
         end
         COOK: begin
            div_run      = 1'b1;
            magnetron_on = door_closed;
            lamp_on      = 1'b1;
            cnt_en       = tick && door_closed;
            if (!door_closed || stop_btn || clear_btn) begin
               state_next = PAUSE;
            end else if (timer_zero) begin
               state_next = DONE;
            end
         end
         PAUSE: begin
            lamp_on = !door_closed;
            if (clear_btn) begin
               state_next = CLR;
            end else if (start_btn && door_closed) begin
               state_next = COOK;
            end
         end
         DONE: begin
            // Counter saturates at BEEP_TICKS; exit is seen the cycle after.
            div_run       = 1'b1;
            beep          = 1'b1;
            beep_cnt_next = tick ? beep_cnt_reg + 1'b1 : beep_cnt_reg;
            if (clear_btn || !door_closed || (beep_cnt_reg == BW'(BEEP_TICKS))) begin
               state_next = CLR;
            end
         end
         default: state_next = CLR;
      endcase
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign load_val[gi*DIGIT_W +: DIGIT_W] = entry_reg[gi*DIGIT_W +: DIGIT_W];
   end
endmodule
